// File: rtl/frame_buffer_arbiter.sv
`timescale 1ns/1ps
// frame_buffer_arbiter: one single-port frame-buffer BRAM shared by display reads, FIFO-buffered camera
// writes and req/gnt detection reads. Define FB_ARB_STATS_EN to add the cam_drop_cnt_out counter port.
module frame_buffer_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 16,
  parameter int WFIFO_DEPTH  = 4,
  parameter int BRAM_LAT     = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              disp_req_in,
  input  logic [ADDR_W-1:0] disp_addr_in,
  output logic [DATA_W-1:0] disp_data_out,
  output logic              disp_valid_out,
  input  logic              cam_valid_in,
  input  logic [ADDR_W-1:0] cam_addr_in,
  input  logic [DATA_W-1:0] cam_data_in,
  output logic              cam_overflow_out,
`ifdef FB_ARB_STATS_EN
  output logic [15:0]       cam_drop_cnt_out,
`endif
  input  logic              det_req_in,
  input  logic [ADDR_W-1:0] det_addr_in,
  output logic              det_gnt_out,
  output logic [DATA_W-1:0] det_data_out,
  output logic              det_valid_out,
  output logic              bram_en_out,
  output logic              bram_we_out,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic [DATA_W-1:0] bram_din_out,
  input  logic [DATA_W-1:0] bram_dout_in
);

  localparam int PTR_W = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] FIFO_FULL     = CNT_W'(WFIFO_DEPTH);
  localparam logic [STV_W-1:0] STARVE_RELOAD = STV_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0] fifo_addr_q [WFIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic              ovf_q, ovf_d;
  logic [STV_W-1:0]  starve_left_q, starve_left_d;

  logic              bram_en_q, bram_en_d;
  logic              bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_din_q, bram_din_d;

  logic [BRAM_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [BRAM_LAT-1:0] pipe_det_q, pipe_det_d;
  logic              disp_valid_q, disp_valid_d;
  logic              det_valid_q, det_valid_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [DATA_W-1:0] det_data_q, det_data_d;

  logic cam_avail, fifo_full, starved;
  logic det_sel, cam_sel, push_ok, drop;

  // starve_left counts denied detect cycles down to zero; zero means detect outranks camera
  assign cam_avail = (fifo_cnt_q != '0);
  assign fifo_full = (fifo_cnt_q == FIFO_FULL);
  assign starved   = (starve_left_q == '0);
  assign det_sel   = !disp_req_in && det_req_in && (starved || !cam_avail);
  assign cam_sel   = !disp_req_in && !det_sel && cam_avail;
  assign push_ok   = cam_valid_in && (!fifo_full || cam_sel);
  assign drop      = cam_valid_in && fifo_full && !cam_sel;

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push_ok) begin
      fifo_addr_d[wr_ptr_q] = cam_addr_in;
      fifo_data_d[wr_ptr_q] = cam_data_in;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (cam_sel) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push_ok) - CNT_W'(cam_sel);
    ovf_d      = ovf_q | drop;

    starve_left_d = starve_left_q;
    if (!det_req_in || det_sel) begin
      starve_left_d = STARVE_RELOAD;
    end else if (!starved) begin
      starve_left_d = starve_left_q - STV_W'(1);
    end
  end

  always_comb begin
    bram_en_d   = 1'b0;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    if (disp_req_in) begin
      bram_en_d   = 1'b1;
      bram_addr_d = disp_addr_in;
    end else if (det_sel) begin
      bram_en_d   = 1'b1;
      bram_addr_d = det_addr_in;
    end else if (cam_sel) begin
      bram_en_d   = 1'b1;
      bram_we_d   = 1'b1;
      bram_addr_d = fifo_addr_q[rd_ptr_q];
      bram_din_d  = fifo_data_q[rd_ptr_q];
    end
  end

  // bram_dout_in is sampled BRAM_LAT edges after the address is launched on bram_addr_out
  always_comb begin
    pipe_vld_d    = pipe_vld_q;
    pipe_det_d    = pipe_det_q;
    pipe_vld_d[0] = disp_req_in || det_sel;
    pipe_det_d[0] = det_sel;
    for (int i = 1; i < BRAM_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_det_d[i] = pipe_det_q[i-1];
    end
    disp_valid_d = pipe_vld_q[BRAM_LAT-1] && !pipe_det_q[BRAM_LAT-1];
    det_valid_d  = pipe_vld_q[BRAM_LAT-1] && pipe_det_q[BRAM_LAT-1];
    disp_data_d  = disp_valid_d ? bram_dout_in : disp_data_q;
    det_data_d   = det_valid_d ? bram_dout_in : det_data_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < WFIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      ovf_q         <= 1'b0;
      starve_left_q <= STARVE_RELOAD;
      bram_en_q     <= 1'b0;
      bram_we_q     <= 1'b0;
      bram_addr_q   <= '0;
      bram_din_q    <= '0;
      pipe_vld_q    <= '0;
      pipe_det_q    <= '0;
      disp_valid_q  <= 1'b0;
      det_valid_q   <= 1'b0;
      disp_data_q   <= '0;
      det_data_q    <= '0;
    end else begin
      fifo_addr_q   <= fifo_addr_d;
      fifo_data_q   <= fifo_data_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      ovf_q         <= ovf_d;
      starve_left_q <= starve_left_d;
      bram_en_q     <= bram_en_d;
      bram_we_q     <= bram_we_d;
      bram_addr_q   <= bram_addr_d;
      bram_din_q    <= bram_din_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_det_q    <= pipe_det_d;
      disp_valid_q  <= disp_valid_d;
      det_valid_q   <= det_valid_d;
      disp_data_q   <= disp_data_d;
      det_data_q    <= det_data_d;
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign cam_drop_cnt_out = drop_cnt_q;
`endif

  // grant is combinational but held low while reset is being applied
  assign det_gnt_out      = det_sel && rst_n_in;
  assign cam_overflow_out = ovf_q;
  assign bram_en_out      = bram_en_q;
  assign bram_we_out      = bram_we_q;
  assign bram_addr_out    = bram_addr_q;
  assign bram_din_out     = bram_din_q;
  assign disp_valid_out   = disp_valid_q;
  assign disp_data_out    = disp_data_q;
  assign det_valid_out    = det_valid_q;
  assign det_data_out     = det_data_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for frame_buffer_arbiter: a queue-based reference model predicts every BRAM op and
// read return; a separate monitor pops and compares as the DUT presents them.
module tb_frame_buffer_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int LAT    = 2;
  localparam int SLIM   = 8;
  localparam int MEM_N  = 131072;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              disp_req_in;
  logic [ADDR_W-1:0] disp_addr_in;
  logic [DATA_W-1:0] disp_data_out;
  logic              disp_valid_out;
  logic              cam_valid_in;
  logic [ADDR_W-1:0] cam_addr_in;
  logic [DATA_W-1:0] cam_data_in;
  logic              cam_overflow_out;
  logic [15:0]       cam_drop_cnt;
  logic              det_req_in;
  logic [ADDR_W-1:0] det_addr_in;
  logic              det_gnt_out;
  logic [DATA_W-1:0] det_data_out;
  logic              det_valid_out;
  logic              bram_en_out;
  logic              bram_we_out;
  logic [ADDR_W-1:0] bram_addr_out;
  logic [DATA_W-1:0] bram_din_out;
  logic [DATA_W-1:0] bram_dout_in;

  always #5 clk_in = ~clk_in;

  frame_buffer_arbiter dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .disp_req_in      (disp_req_in),
    .disp_addr_in     (disp_addr_in),
    .disp_data_out    (disp_data_out),
    .disp_valid_out   (disp_valid_out),
    .cam_valid_in     (cam_valid_in),
    .cam_addr_in      (cam_addr_in),
    .cam_data_in      (cam_data_in),
    .cam_overflow_out (cam_overflow_out),
`ifdef FB_ARB_STATS_EN
    .cam_drop_cnt_out (cam_drop_cnt),
`endif
    .det_req_in       (det_req_in),
    .det_addr_in      (det_addr_in),
    .det_gnt_out      (det_gnt_out),
    .det_data_out     (det_data_out),
    .det_valid_out    (det_valid_out),
    .bram_en_out      (bram_en_out),
    .bram_we_out      (bram_we_out),
    .bram_addr_out    (bram_addr_out),
    .bram_din_out     (bram_din_out),
    .bram_dout_in     (bram_dout_in)
  );

`ifndef FB_ARB_STATS_EN
  assign cam_drop_cnt = 16'h0000;
`endif

  // BRAM environment: one registered read stage plus the DUT capture register gives BRAM_LAT=2
  logic [DATA_W-1:0] bram_mem [MEM_N];
  logic [DATA_W-1:0] ref_mem  [MEM_N];
  logic [DATA_W-1:0] bram_rd_q = '0;

  always @(posedge clk_in) begin
    if (bram_en_out) begin
      if (bram_we_out) bram_mem[bram_addr_out] <= bram_din_out;
      else             bram_rd_q <= bram_mem[bram_addr_out];
    end
  end
  assign bram_dout_in = bram_rd_q;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} cam_t;
  typedef struct packed {logic en; logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] din;} op_t;
  typedef struct packed {logic [DATA_W-1:0] data; logic [31:0] due;} rd_t;

  cam_t m_fifo[$];
  op_t  exp_op[$];
  rd_t  exp_disp[$];
  rd_t  exp_det[$];
  int   m_starve = 0;
  bit   m_ovf    = 0;
  int   m_drops  = 0;
  bit   m_gnt    = 0;
  bit   dut_gnt_s = 0;

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return 16'(a) ^ ((a >= 65536) ? 16'h5555 : 16'h0000);
  endfunction

  // Reference model: one arbitration decision per cycle from the priority rules
  always @(negedge clk_in) begin : ref_model
    op_t  op;
    rd_t  r;
    cam_t c;
    op        = '0;
    dut_gnt_s = det_gnt_out;
    chk("overflow", cam_overflow_out, m_ovf);
`ifdef FB_ARB_STATS_EN
    chk("drop_cnt", cam_drop_cnt, (m_drops > 65535) ? 32'd65535 : 32'(m_drops));
`endif
    if (!rst_n_in) begin
      m_fifo.delete();
      exp_disp.delete();
      exp_det.delete();
      exp_op.delete();
      m_starve = 0;
      m_ovf    = 0;
      m_drops  = 0;
      m_gnt    = 0;
      chk("det_gnt_in_reset", det_gnt_out, 0);
      exp_op.push_back(op);
    end else begin
      m_gnt = 0;
      if (disp_req_in) begin
        op.en  = 1'b1;
        op.addr = disp_addr_in;
        r.data = ref_mem[disp_addr_in];
        r.due  = 32'(cyc + 1 + LAT);
        exp_disp.push_back(r);
      end else if (det_req_in && (m_starve >= SLIM || m_fifo.size() == 0)) begin
        m_gnt   = 1;
        op.en   = 1'b1;
        op.addr = det_addr_in;
        r.data  = ref_mem[det_addr_in];
        r.due   = 32'(cyc + 1 + LAT);
        exp_det.push_back(r);
      end else if (m_fifo.size() > 0) begin
        c       = m_fifo.pop_front();
        op.en   = 1'b1;
        op.we   = 1'b1;
        op.addr = c.addr;
        op.din  = c.data;
        ref_mem[c.addr] = c.data;
      end
      chk("det_gnt", det_gnt_out, m_gnt);
      if (!det_req_in || m_gnt) m_starve = 0;
      else if (m_starve < SLIM) m_starve++;
      if (cam_valid_in) begin
        if (m_fifo.size() < DEPTH) begin
          c.addr = cam_addr_in;
          c.data = cam_data_in;
          m_fifo.push_back(c);
        end else begin
          m_ovf = 1;
          m_drops++;
        end
      end
      exp_op.push_back(op);
    end
  end

  always @(posedge clk_in) begin : monitor
    op_t e;
    rd_t r;
    #2;
    if (exp_op.size() > 0) begin
      e = exp_op.pop_front();
      chk("bram_en", bram_en_out, e.en);
      if (e.en) begin
        chk("bram_we", bram_we_out, e.we);
        chk("bram_addr", bram_addr_out, e.addr);
        if (e.we) chk("bram_din", bram_din_out, e.din);
      end else begin
        chk("bram_we_idle", bram_we_out, 0);
      end
    end else if (bram_en_out) begin
      chk("bram_en_unexpected", bram_en_out, 0);
    end
    if (exp_disp.size() > 0 && exp_disp[0].due < 32'(cyc)) begin
      chk("disp_valid_missing", cyc, exp_disp[0].due);
      void'(exp_disp.pop_front());
    end
    if (exp_det.size() > 0 && exp_det[0].due < 32'(cyc)) begin
      chk("det_valid_missing", cyc, exp_det[0].due);
      void'(exp_det.pop_front());
    end
    if (disp_valid_out) begin
      if (exp_disp.size() == 0) chk("disp_valid_unexpected", disp_valid_out, 0);
      else begin
        r = exp_disp.pop_front();
        chk("disp_data", disp_data_out, r.data);
        chk("disp_latency", cyc, r.due);
      end
    end
    if (det_valid_out) begin
      if (exp_det.size() == 0) chk("det_valid_unexpected", det_valid_out, 0);
      else begin
        r = exp_det.pop_front();
        chk("det_data", det_data_out, r.data);
        chk("det_latency", cyc, r.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    disp_req_in  = 1'b0;
    cam_valid_in = 1'b0;
    det_req_in   = 1'b0;
    repeat (n) tick();
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(3) == 0) return 17'($urandom);
    return 17'($urandom_range(63));
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_bram_en"}, bram_en_out, 0);
    chk({tag, "_bram_we"}, bram_we_out, 0);
    chk({tag, "_bram_addr"}, bram_addr_out, 0);
    chk({tag, "_bram_din"}, bram_din_out, 0);
    chk({tag, "_disp_valid"}, disp_valid_out, 0);
    chk({tag, "_disp_data"}, disp_data_out, 0);
    chk({tag, "_det_valid"}, det_valid_out, 0);
    chk({tag, "_det_data"}, det_data_out, 0);
    chk({tag, "_overflow"}, cam_overflow_out, 0);
`ifdef FB_ARB_STATS_EN
    chk({tag, "_drop_cnt"}, cam_drop_cnt, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cnt;
    bit got;
    for (int a = 0; a < MEM_N; a++) begin
      bram_mem[a] = init_val(a);
      ref_mem[a]  = init_val(a);
    end
    rst_n_in     = 1'b0;
    disp_req_in  = 1'b0;
    disp_addr_in = '0;
    cam_valid_in = 1'b0;
    cam_addr_in  = '0;
    cam_data_in  = '0;
    det_req_in   = 1'b0;
    det_addr_in  = '0;
    repeat (3) tick();
    chk_outputs_zero("reset");
    rst_n_in = 1'b1;

    for (int i = 0; i < 240; i++) begin
      disp_req_in  = 1'b1;
      disp_addr_in = 17'(i);
      tick();
    end
    idle(6);

    for (int i = 0; i < 4; i++) begin
      cam_valid_in = 1'b1;
      cam_addr_in  = 17'(100 + i);
      cam_data_in  = 16'(16'hA0 + i);
      tick();
    end
    idle(4);
    disp_req_in  = 1'b1;
    disp_addr_in = 17'd101;
    tick();
    idle(4);
    chk("readback_101", disp_data_out, 16'hA1);

    for (int i = 0; i < 6; i++) begin
      disp_req_in  = 1'b1;
      disp_addr_in = 17'(300 + i);
      cam_valid_in = 1'b1;
      cam_addr_in  = 17'(200 + i);
      cam_data_in  = 16'(16'hB0 + i);
      tick();
    end
    cam_valid_in = 1'b0;
    tick();
    chk("overflow_sticky", cam_overflow_out, 1);
`ifdef FB_ARB_STATS_EN
    chk("drop_cnt_two", cam_drop_cnt, 2);
`endif
    idle(8);

    for (int i = 0; i < 2; i++) begin
      cam_valid_in = 1'b1;
      cam_addr_in  = 17'(400 + i);
      cam_data_in  = 16'(16'hC0 + i);
      tick();
    end
    got = 0;
    k   = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      det_req_in   = 1'b1;
      det_addr_in  = 17'h00123;
      cam_valid_in = 1'b1;
      cam_addr_in  = 17'(402 + i);
      cam_data_in  = 16'(16'hC2 + i);
      tick();
      if (dut_gnt_s) begin
        got = 1;
        k   = i;
      end
    end
    chk("starve_gnt_seen", 32'(got), 1);
    chk("starve_gnt_within_limit", 32'(k <= SLIM), 1);
    idle(8);

    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      disp_req_in  = 1'b1;
      disp_addr_in = 17'(500 + i);
      det_req_in   = 1'b1;
      det_addr_in  = 17'h00055;
      tick();
      if (dut_gnt_s) cnt++;
    end
    chk("det_blocked_by_disp", cnt, 0);
    disp_req_in = 1'b0;
    tick();
    chk("det_gnt_after_disp", dut_gnt_s, 1);
    idle(6);

    for (int i = 0; i < 3000; i++) begin
      disp_req_in  = ($urandom_range(99) < 45);
      disp_addr_in = rand_addr();
      cam_valid_in = ($urandom_range(99) < 35);
      cam_addr_in  = rand_addr();
      cam_data_in  = 16'($urandom);
      if (!det_req_in && $urandom_range(2) == 0) begin
        det_req_in  = 1'b1;
        det_addr_in = rand_addr();
      end
      tick();
      if (dut_gnt_s) det_req_in = 1'b0;
    end
    idle(10);

    disp_req_in  = 1'b1;
    disp_addr_in = 17'd5;
    tick();
    disp_req_in = 1'b0;
    rst_n_in    = 1'b0;
    tick();
    rst_n_in = 1'b1;
    chk_outputs_zero("post_reset");
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (disp_valid_out) cnt++;
    end
    chk("no_valid_after_reset", cnt, 0);

    idle(5);
    chk("disp_queue_drained", exp_disp.size(), 0);
    chk("det_queue_drained", exp_det.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
